// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and the flop stages it feeds.
// The sequencer owns the reset outputs; the soft request comes from software control.
interface reset_sequencer_if;
    logic       soft_rst_req;
    logic       rst_async;
    logic       rst_sync;
    logic       ready;
    logic [1:0] state;

    modport master (
        input  soft_rst_req,
        output rst_async,
        output rst_sync,
        output ready,
        output state
    );

    modport slave (
        output soft_rst_req,
        input  rst_async,
        input  rst_sync,
        input  ready,
        input  state
    );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: async-assert / sync-release reset with a post-release hold,
// plus fixed-length synchronous soft-reset pulses triggered by request rising edges.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int SOFT_CYCLES = 3,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_async_n,
    reset_sequencer_if.master     seq_bus
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $fatal(1, "reset_sequencer: SYNC_STAGES must be >= 2");
        end
        if (HOLD_CYCLES < 1 || SOFT_CYCLES < 1) begin : g_bad_count
            $fatal(1, "reset_sequencer: HOLD_CYCLES and SOFT_CYCLES must be >= 1");
        end
        if (CNT_W < 1 || CNT_W > 31) begin : g_bad_width
            $fatal(1, "reset_sequencer: CNT_W must be in 1..31");
        end else if (HOLD_CYCLES >= (1 << CNT_W) || SOFT_CYCLES >= (1 << CNT_W)) begin : g_bad_fit
            $fatal(1, "reset_sequencer: CNT_W too narrow for HOLD_CYCLES/SOFT_CYCLES");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_SOFT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_chain_reg;
    state_t                 state_reg;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   req_prev_reg;
    logic                   rst_async_reg;
    logic                   rst_async_next;
    logic                   rst_sync_reg;
    logic                   rst_sync_next;
    logic                   ready_reg;
    logic                   ready_next;
    logic                   soft_trigger;
    logic                   release_edge;

    // Release synchronizer: ones shift in from the low end after rst_async_n rises.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            sync_chain_reg <= '0;
        end else begin
            sync_chain_reg <= {sync_chain_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // HOLD is entered on the same edge the last chain stage turns 1, so the
    // release lands exactly SYNC_STAGES+HOLD_CYCLES edges after reset removal.
    assign release_edge = sync_chain_reg[SYNC_STAGES-2];
    assign soft_trigger = seq_bus.soft_rst_req & ~req_prev_reg;

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state_reg     <= ST_ASSERT;
            cnt_reg       <= '0;
            req_prev_reg  <= 1'b0;
            rst_async_reg <= 1'b1;
            rst_sync_reg  <= 1'b0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            req_prev_reg  <= seq_bus.soft_rst_req;
            rst_async_reg <= rst_async_next;
            rst_sync_reg  <= rst_sync_next;
            ready_reg     <= ready_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_ASSERT: begin
                cnt_next = '0;
                if (release_edge) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_next = '0;
                if (soft_trigger) begin
                    state_next = ST_SOFT;
                end
            end
            ST_SOFT: begin
                // Requests arriving mid-pulse are dropped, not queued.
                if (cnt_reg == SOFT_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_ASSERT;
                cnt_next   = '0;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they
        // change on the same edge as the state and never glitch.
        rst_async_next = (state_next == ST_ASSERT) || (state_next == ST_HOLD);
        rst_sync_next  = (state_next == ST_SOFT);
        ready_next     = (state_next == ST_RUN);
    end

    assign seq_bus.rst_async = rst_async_reg;
    assign seq_bus.rst_sync  = rst_sync_reg;
    assign seq_bus.ready     = ready_reg;
    assign seq_bus.state     = state_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random
// request/reset traffic, compared against an edge-counting reference model.
module tb_reset_sequencer;

    localparam int S   = 2;
    localparam int H   = 4;
    localparam int SC  = 3;
    localparam int RL  = S + H;

    logic clk = 1'b0;
    logic rst_async_n;

    reset_sequencer_if seq_bus();

    reset_sequencer #(
        .SYNC_STAGES (S),
        .HOLD_CYCLES (H),
        .SOFT_CYCLES (SC),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst_async_n (rst_async_n),
        .seq_bus     (seq_bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: edges since release and cycles of soft pulse remaining.
    int m_rel   = 0;
    int m_pulse = 0;
    bit m_prev  = 1'b0;
    bit m_trig;

    always @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            m_rel   = 0;
            m_pulse = 0;
            m_prev  = 1'b0;
        end else begin
            m_trig = seq_bus.soft_rst_req && !m_prev;
            m_prev = seq_bus.soft_rst_req;
            if (m_rel < RL) m_rel++;
            else if (m_pulse > 0) m_pulse--;
            else if (m_trig) m_pulse = SC;
        end
    end

    function automatic logic [4:0] model_vec();
        logic       ra, rs, rd;
        logic [1:0] st;
        ra = (m_rel < RL);
        rs = (m_rel >= RL) && (m_pulse > 0);
        rd = (m_rel >= RL) && (m_pulse == 0);
        if (m_rel < S)       st = 2'd0;
        else if (m_rel < RL) st = 2'd1;
        else if (m_pulse > 0) st = 2'd3;
        else                 st = 2'd2;
        return {ra, rs, rd, st};
    endfunction

    function automatic logic [4:0] dut_vec();
        return {seq_bus.rst_async, seq_bus.rst_sync, seq_bus.ready, seq_bus.state};
    endfunction

    task automatic test_reset();
        logic [4:0] obs;
        rst_async_n = 1'b0;
        seq_bus.soft_rst_req = 1'b0;
        #20;
        obs = dut_vec();
        n_cmp++;
        if (obs !== 5'b1_0_0_00) begin
            n_err++;
            $display("FAIL reset_state: got %b expected %b", obs, 5'b10000);
        end
        @(negedge clk);
        rst_async_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            obs = dut_vec();
            n_cmp++;
            if (obs !== model_vec()) begin
                n_err++;
                $display("FAIL power_on_edge%0d: got %b expected %b", e, obs, model_vec());
            end
            n_cmp++;
            if ({obs[4], obs[2]} !== {(e < RL), (e >= RL)}) begin
                n_err++;
                $display("FAIL release_timing_edge%0d: rst_async/ready got %b expected %b",
                         e, {obs[4], obs[2]}, {(e < RL), (e >= RL)});
            end
        end
        $display("test_reset done at %0t", $time);
    endtask

    task automatic test_single_soft();
        logic [4:0] obs;
        int hi_cnt = 0;
        seq_bus.soft_rst_req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) seq_bus.soft_rst_req = 1'b0;
            obs = dut_vec();
            if (obs[3]) hi_cnt++;
            n_cmp++;
            if (obs !== model_vec()) begin
                n_err++;
                $display("FAIL single_soft_c%0d: got %b expected %b", c, obs, model_vec());
            end
            if (c == 0 || c == 3) begin
                n_cmp++;
                if (obs[1:0] !== ((c == 0) ? 2'd3 : 2'd2)) begin
                    n_err++;
                    $display("FAIL single_soft_state_c%0d: got %0d expected %0d",
                             c, obs[1:0], (c == 0) ? 3 : 2);
                end
            end
        end
        n_cmp++;
        if (hi_cnt !== SC) begin
            n_err++;
            $display("FAIL single_soft_len: got %0d expected %0d", hi_cnt, SC);
        end
        $display("test_single_soft done: pulse length %0d", hi_cnt);
    endtask

    task automatic test_held_repeat();
        logic [4:0] obs;
        bit pat [0:23];
        int rises = 0;
        int highs = 0;
        bit last_sync = 1'b0;
        pat = '{1,1,1,1,1,1,1,1,1,1, 0, 1, 0, 1, 0,0,0,0, 1, 0,0,0,0,0};
        for (int i = 0; i < 24; i++) begin
            seq_bus.soft_rst_req = pat[i];
            @(negedge clk);
            obs = dut_vec();
            if (obs[3]) highs++;
            if (obs[3] && !last_sync) rises++;
            last_sync = obs[3];
            n_cmp++;
            if (obs !== model_vec()) begin
                n_err++;
                $display("FAIL held_repeat_i%0d: got %b expected %b", i, obs, model_vec());
            end
        end
        n_cmp++;
        if (rises !== 3 || highs !== 3 * SC) begin
            n_err++;
            $display("FAIL held_repeat_pulses: got %0d pulses/%0d cycles expected 3/%0d",
                     rises, highs, 3 * SC);
        end
        $display("test_held_repeat done: %0d pulses", rises);
    endtask

    task automatic test_async_mid_pulse();
        logic [4:0] obs;
        seq_bus.soft_rst_req = 1'b1;
        @(negedge clk);
        seq_bus.soft_rst_req = 1'b0;
        @(posedge clk);
        #3;
        rst_async_n = 1'b0;
        #1;
        obs = dut_vec();
        n_cmp++;
        if (obs !== 5'b1_0_0_00) begin
            n_err++;
            $display("FAIL async_mid_pulse_immediate: got %b expected %b", obs, 5'b10000);
        end
        @(negedge clk);
        rst_async_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            obs = dut_vec();
            n_cmp++;
            if (obs !== model_vec() || obs[4] !== (e < RL)) begin
                n_err++;
                $display("FAIL async_mid_pulse_edge%0d: got %b expected %b", e, obs, model_vec());
            end
        end
        $display("test_async_mid_pulse done at %0t", $time);
    endtask

    task automatic test_req_held_through_reset();
        logic [4:0] obs;
        rst_async_n = 1'b0;
        seq_bus.soft_rst_req = 1'b1;
        #20;
        @(negedge clk);
        rst_async_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            if (e == 12) seq_bus.soft_rst_req = 1'b0;
            obs = dut_vec();
            n_cmp++;
            if (obs[3] !== 1'b0 || obs[2] !== (e >= RL) || obs !== model_vec()) begin
                n_err++;
                $display("FAIL held_through_reset_edge%0d: got %b expected %b", e, obs, model_vec());
            end
        end
        $display("test_req_held_through_reset done at %0t", $time);
    endtask

    task automatic test_glitch_hold();
        logic [4:0] obs;
        rst_async_n = 1'b0;
        @(negedge clk);
        rst_async_n = 1'b1;
        repeat (S + 1) @(negedge clk);
        obs = dut_vec();
        n_cmp++;
        if (obs[1:0] !== 2'd1) begin
            n_err++;
            $display("FAIL glitch_in_hold_pre: state got %0d expected 1", obs[1:0]);
        end
        @(posedge clk);
        #2;
        rst_async_n = 1'b0;
        #1;
        obs = dut_vec();
        n_cmp++;
        if (obs !== 5'b1_0_0_00) begin
            n_err++;
            $display("FAIL glitch_in_hold_immediate: got %b expected %b", obs, 5'b10000);
        end
        #1;
        rst_async_n = 1'b1;
        @(negedge clk);
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            obs = dut_vec();
            n_cmp++;
            if (obs !== model_vec() || obs[2] !== (e >= RL)) begin
                n_err++;
                $display("FAIL glitch_restart_edge%0d: got %b expected %b", e, obs, model_vec());
            end
        end
        $display("test_glitch_hold done at %0t", $time);
    endtask

    task automatic test_random();
        logic [4:0] obs;
        int low_left = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            obs = dut_vec();
            n_cmp++;
            if (obs !== model_vec() || (obs[4] && obs[3])) begin
                n_err++;
                $display("FAIL random_c%0d: got %b expected %b", c, obs, model_vec());
            end
            if ($urandom_range(0, 2) == 0) seq_bus.soft_rst_req = ~seq_bus.soft_rst_req;
            if (low_left > 0) begin
                low_left--;
                if (low_left == 0) rst_async_n = 1'b1;
            end else if ($urandom_range(0, 59) == 0) begin
                rst_async_n = 1'b0;
                low_left = int'($urandom_range(1, 3));
            end
        end
        rst_async_n = 1'b1;
        $display("test_random done: 400 cycles");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_async_n = 1'b0;
        seq_bus.soft_rst_req = 1'b0;
        test_reset();
        test_single_soft();
        test_held_repeat();
        test_async_mid_pulse();
        test_req_held_through_reset();
        test_glitch_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
